rs_multi_cdb: RTL and testbench

//  Parametrised reservation station for the out-of-order core. Sits between dispatch and the FU array.

---
 rtl/rs_multi_cdb.sv | 244 ++++++++++++++++++++++++
 tb/tb_rs_multi_cdb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_multi_cdb.sv
// ============================================================================
// Module   : rs_multi_cdb
// Brief    : Shared reservation station with multi-channel CDB wakeup and
//            one issue per FU type per cycle.
// Config   : RS_AGE_SELECT_EN - when defined, each port issues the oldest
//            eligible entry (age matrix); otherwise the lowest-index one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_multi_cdb #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_FU      = 4,
  parameter int NUM_CDB     = 2,
  parameter int TAG_W       = 6,
  parameter int FU_W        = 2,
  localparam int OCC_W      = $clog2(NUM_ENTRIES + 1),
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       disp_valid_i,
  output logic                       disp_ready_o,
  input  logic [FU_W-1:0]            disp_fu_i,
  input  logic [TAG_W-1:0]           disp_dest_i,
  input  logic [TAG_W-1:0]           disp_t1_idx_i,
  input  logic                       disp_t1_rdy_i,
  input  logic [TAG_W-1:0]           disp_t2_idx_i,
  input  logic                       disp_t2_rdy_i,
  input  logic [NUM_CDB-1:0]         cdb_valid_i,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag_i,
  input  logic [NUM_FU-1:0]          fu_ready_i,
  output logic [NUM_FU-1:0]          iss_valid_o,
  output logic [NUM_FU*TAG_W-1:0]    iss_dest_o,
  output logic [NUM_FU*TAG_W-1:0]    iss_t1_idx_o,
  output logic [NUM_FU*TAG_W-1:0]    iss_t2_idx_o,
  output logic [OCC_W-1:0]           occupancy_o
);

  // Entry storage
  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [NUM_ENTRIES-1:0] t1_rdy_q, t1_rdy_d;
  logic [NUM_ENTRIES-1:0] t2_rdy_q, t2_rdy_d;
  logic [FU_W-1:0]        fu_q     [NUM_ENTRIES];
  logic [FU_W-1:0]        fu_d     [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_q   [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_d   [NUM_ENTRIES];
  logic [TAG_W-1:0]       t1_idx_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       t1_idx_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       t2_idx_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       t2_idx_d [NUM_ENTRIES];
  logic [OCC_W-1:0]       occ_q, occ_d;

`ifdef RS_AGE_SELECT_EN
  // age_q[i][j] = 1 means entry i was dispatched before entry j
  logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] age_d [NUM_ENTRIES];
`endif

  logic                   w_issue_en;
  logic [NUM_ENTRIES-1:0] w_elig;
  logic [NUM_ENTRIES-1:0] w_issued;
  logic [OCC_W-1:0]       w_n_issued;
  logic                   w_disp_fire;
  logic [IDX_W-1:0]       w_free_idx;

  // True when any valid CDB channel carries the given tag
  function automatic logic cdb_hit(input logic [TAG_W-1:0]         tag,
                                   input logic [NUM_CDB-1:0]       vld,
                                   input logic [NUM_CDB*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Eligibility from registered ready bits only, so wakeup never issues same cycle
  always_comb begin
    w_issue_en = en_i & ~flush_i;
    w_elig     = busy_q & t1_rdy_q & t2_rdy_q;
  end

  // Per-port selection of one eligible entry and issue output drive
  always_comb begin
    logic [NUM_ENTRIES-1:0] cand;
    logic [IDX_W-1:0]       pick;
    logic                   found;
`ifdef RS_AGE_SELECT_EN
    logic                   older;
`endif
    cand         = '0;
    pick         = '0;
    found        = 1'b0;
`ifdef RS_AGE_SELECT_EN
    older        = 1'b0;
`endif
    w_issued     = '0;
    iss_valid_o  = '0;
    iss_dest_o   = '0;
    iss_t1_idx_o = '0;
    iss_t2_idx_o = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        cand[e] = w_elig[e] && (fu_q[e] == FU_W'(f));
      end
      pick  = '0;
      found = 1'b0;
`ifdef RS_AGE_SELECT_EN
      // Oldest candidate: no other candidate is older than it
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        older = 1'b0;
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          if (cand[j] && age_q[j][e]) older = 1'b1;
        end
        if (cand[e] && !older && !found) begin
          found = 1'b1;
          pick  = IDX_W'(e);
        end
      end
`else
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (cand[e] && !found) begin
          found = 1'b1;
          pick  = IDX_W'(e);
        end
      end
`endif
      // An entry carries a single FU type, so it can never win two ports
      if (w_issue_en && fu_ready_i[f] && found) begin
        iss_valid_o[f]                   = 1'b1;
        w_issued[pick]                   = 1'b1;
        iss_dest_o[f*TAG_W +: TAG_W]     = dest_q[pick];
        iss_t1_idx_o[f*TAG_W +: TAG_W]   = t1_idx_q[pick];
        iss_t2_idx_o[f*TAG_W +: TAG_W]   = t2_idx_q[pick];
      end
    end
  end

  // Dispatch acceptance and lowest free slot (free in current state only)
  always_comb begin
    logic found;
    found        = 1'b0;
    w_free_idx   = '0;
    disp_ready_o = en_i & ~flush_i & ~(&busy_q);
    w_disp_fire  = disp_valid_i & disp_ready_o;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      if (!busy_q[e] && !found) begin
        found      = 1'b1;
        w_free_idx = IDX_W'(e);
      end
    end
  end

  // Count of entries leaving via issue this cycle
  always_comb begin
    w_n_issued = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_n_issued = w_n_issued + OCC_W'(w_issued[e]);
    end
  end

  // Next-state: flush dominates, otherwise wakeup, issue retire and dispatch when enabled
  always_comb begin
    busy_d   = busy_q;
    t1_rdy_d = t1_rdy_q;
    t2_rdy_d = t2_rdy_q;
    fu_d     = fu_q;
    dest_d   = dest_q;
    t1_idx_d = t1_idx_q;
    t2_idx_d = t2_idx_q;
    occ_d    = occ_q;
`ifdef RS_AGE_SELECT_EN
    age_d    = age_q;
`endif
    if (flush_i) begin
      busy_d = '0;
      occ_d  = '0;
`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < NUM_ENTRIES; i++) age_d[i] = '0;
`endif
    end else if (en_i) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (busy_q[e] && cdb_hit(t1_idx_q[e], cdb_valid_i, cdb_tag_i)) t1_rdy_d[e] = 1'b1;
        if (busy_q[e] && cdb_hit(t2_idx_q[e], cdb_valid_i, cdb_tag_i)) t2_rdy_d[e] = 1'b1;
      end
      busy_d = busy_d & ~w_issued;
      if (w_disp_fire) begin
        busy_d[w_free_idx]   = 1'b1;
        fu_d[w_free_idx]     = disp_fu_i;
        dest_d[w_free_idx]   = disp_dest_i;
        t1_idx_d[w_free_idx] = disp_t1_idx_i;
        t2_idx_d[w_free_idx] = disp_t2_idx_i;
        t1_rdy_d[w_free_idx] = disp_t1_rdy_i | cdb_hit(disp_t1_idx_i, cdb_valid_i, cdb_tag_i);
        t2_rdy_d[w_free_idx] = disp_t2_rdy_i | cdb_hit(disp_t2_idx_i, cdb_valid_i, cdb_tag_i);
`ifdef RS_AGE_SELECT_EN
        // Every currently busy entry is older than the newcomer
        for (int i = 0; i < NUM_ENTRIES; i++) age_d[i][w_free_idx] = busy_q[i];
        age_d[w_free_idx] = '0;
`endif
      end
      occ_d = occ_q + OCC_W'(w_disp_fire) - w_n_issued;
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= '0;
      t1_rdy_q <= '0;
      t2_rdy_q <= '0;
      occ_q    <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        fu_q[e]     <= '0;
        dest_q[e]   <= '0;
        t1_idx_q[e] <= '0;
        t2_idx_q[e] <= '0;
`ifdef RS_AGE_SELECT_EN
        age_q[e]    <= '0;
`endif
      end
    end else begin
      busy_q   <= busy_d;
      t1_rdy_q <= t1_rdy_d;
      t2_rdy_q <= t2_rdy_d;
      occ_q    <= occ_d;
      fu_q     <= fu_d;
      dest_q   <= dest_d;
      t1_idx_q <= t1_idx_d;
      t2_idx_q <= t2_idx_d;
`ifdef RS_AGE_SELECT_EN
      age_q    <= age_d;
`endif
    end
  end

  assign occupancy_o = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_multi_cdb.sv
// ============================================================================
// Module   : tb_rs_multi_cdb
// Brief    : Directed plus random bench for rs_multi_cdb against a
//            sequence-number based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_multi_cdb;

  localparam int NE = 8;
  localparam int NF = 4;
  localparam int NC = 2;
  localparam int TW = 6;
  localparam int FW = 2;
  localparam int OW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en, flush, disp_valid, disp_ready;
  logic [FW-1:0]   disp_fu;
  logic [TW-1:0]   disp_dest, disp_t1, disp_t2;
  logic            disp_t1r, disp_t2r;
  logic [NC-1:0]   cdb_valid;
  logic [NC*TW-1:0] cdb_tag;
  logic [NF-1:0]   fu_ready, iss_valid;
  logic [NF*TW-1:0] iss_dest, iss_t1, iss_t2;
  logic [OW-1:0]   occupancy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rs_multi_cdb dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush),
    .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_fu_i(disp_fu),
    .disp_dest_i(disp_dest), .disp_t1_idx_i(disp_t1), .disp_t1_rdy_i(disp_t1r),
    .disp_t2_idx_i(disp_t2), .disp_t2_rdy_i(disp_t2r),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .fu_ready_i(fu_ready),
    .iss_valid_o(iss_valid), .iss_dest_o(iss_dest), .iss_t1_idx_o(iss_t1),
    .iss_t2_idx_o(iss_t2), .occupancy_o(occupancy)
  );

  // Reference model: each op remembers when it was dispatched
  bit m_busy [NE];
  bit m_r1   [NE];
  bit m_r2   [NE];
  int m_fu   [NE];
  int m_dest [NE];
  int m_t1   [NE];
  int m_t2   [NE];
  int m_seq  [NE];
  int next_seq = 0;
  int pick   [NF];

  function automatic bit hit(input int t);
    for (int c = 0; c < NC; c++)
      if (cdb_valid[c] && (int'(cdb_tag[c*TW +: TW]) == t)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int e = 0; e < NE; e++) n += int'(m_busy[e]);
    return n;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < NE; e++) begin
      m_busy[e] = 0; m_r1[e] = 0; m_r2[e] = 0;
      m_fu[e] = 0; m_dest[e] = 0; m_t1[e] = 0; m_t2[e] = 0; m_seq[e] = 0;
    end
  endtask

  task automatic compute_picks();
    for (int f = 0; f < NF; f++) begin
      pick[f] = -1;
      if (en && !flush && fu_ready[f]) begin
        for (int e = 0; e < NE; e++) begin
          if (m_busy[e] && m_r1[e] && m_r2[e] && m_fu[e] == f) begin
`ifdef RS_AGE_SELECT_EN
            if (pick[f] < 0 || m_seq[e] < m_seq[pick[f]]) pick[f] = e;
`else
            if (pick[f] < 0) pick[f] = e;
`endif
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare combinational/registered outputs, then advance the model
  task automatic step();
    logic [NF-1:0]    ev;
    logic [NF*TW-1:0] ed, e1, e2;
    int cnt, slot;
    compute_picks();
    cnt = busy_count();
    ev = '0; ed = '0; e1 = '0; e2 = '0;
    for (int f = 0; f < NF; f++) begin
      if (pick[f] >= 0) begin
        ev[f] = 1'b1;
        ed[f*TW +: TW] = TW'(m_dest[pick[f]]);
        e1[f*TW +: TW] = TW'(m_t1[pick[f]]);
        e2[f*TW +: TW] = TW'(m_t2[pick[f]]);
      end
    end
    #1;
    chk("disp_ready", 32'(disp_ready), 32'(en && !flush && cnt < NE));
    chk("occupancy",  32'(occupancy),  32'(cnt));
    chk("iss_valid",  32'(iss_valid),  32'(ev));
    chk("iss_dest",   32'(iss_dest),   32'(ed));
    chk("iss_t1",     32'(iss_t1),     32'(e1));
    chk("iss_t2",     32'(iss_t2),     32'(e2));
    @(posedge clk);
    if (flush) begin
      for (int e = 0; e < NE; e++) m_busy[e] = 0;
    end else if (en) begin
      slot = -1;
      if (disp_valid && cnt < NE)
        for (int e = NE - 1; e >= 0; e--) if (!m_busy[e]) slot = e;
      for (int e = 0; e < NE; e++) begin
        if (m_busy[e] && hit(m_t1[e])) m_r1[e] = 1;
        if (m_busy[e] && hit(m_t2[e])) m_r2[e] = 1;
      end
      for (int f = 0; f < NF; f++) if (pick[f] >= 0) m_busy[pick[f]] = 0;
      if (slot >= 0) begin
        m_busy[slot] = 1;
        m_fu[slot]   = int'(disp_fu);
        m_dest[slot] = int'(disp_dest);
        m_t1[slot]   = int'(disp_t1);
        m_t2[slot]   = int'(disp_t2);
        m_r1[slot]   = disp_t1r || hit(int'(disp_t1));
        m_r2[slot]   = disp_t2r || hit(int'(disp_t2));
        m_seq[slot]  = next_seq++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    en = 1'b1; flush = 1'b0; disp_valid = 1'b0; cdb_valid = '0; cdb_tag = '0;
    disp_fu = '0; disp_dest = '0; disp_t1 = '0; disp_t2 = '0;
    disp_t1r = 1'b0; disp_t2r = 1'b0;
  endtask

  task automatic disp(input int fu, input int dest, input int t1, input int r1,
                      input int t2, input int r2);
    disp_valid = 1'b1;
    disp_fu = FW'(fu); disp_dest = TW'(dest);
    disp_t1 = TW'(t1); disp_t1r = (r1 != 0);
    disp_t2 = TW'(t2); disp_t2r = (r2 != 0);
  endtask

  initial begin
    idle(); fu_ready = '0; model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();                                   // reset state

    // Reset mid-run with five ready, busy entries
    for (int i = 0; i < 5; i++) begin
      disp(i % 4, 16 + i, i, 1, i + 1, 1); fu_ready = '0; step();
    end
    idle(); step();
    fu_ready = '1; rst_n = 1'b0; #1;
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1; fu_ready = '0;
    step();

    // Fill to full, refuse a ninth, then wake entry 3 by CDB channel 0
    for (int i = 0; i < 8; i++) begin
      disp((i == 3) ? 2 : 0, 8 + i, (i == 3) ? 5 : 32 + i, 0, 63, 1); step();
    end
    disp(1, 0, 0, 1, 0, 1); step();
    idle(); cdb_valid = 2'b01; cdb_tag = {6'h00, 6'h05}; fu_ready = '1; step();
    idle(); step();
    idle(); flush = 1'b1; step();

    // Dispatch bypass from CDB channel 1
    idle(); disp(1, 42, 18, 0, 1, 1); cdb_valid = 2'b10; cdb_tag = {6'h12, 6'h00}; step();
    idle(); step();

    // Two channels wake both sources of one entry together
    disp(2, 43, 7, 0, 9, 0); step();
    idle(); cdb_valid = 2'b11; cdb_tag = {6'h09, 6'h07}; step();
    idle(); step(); step();
    idle(); flush = 1'b1; step();

    // Older entry 6 versus younger entry 1 on FU 0
    idle(); fu_ready = '0;
    for (int i = 0; i < 8; i++) begin
      disp((i == 6) ? 0 : 3, 48 + i, 48 + i, 0, 63, 1); step();
    end
    idle(); cdb_valid = 2'b01; cdb_tag = {6'h00, 6'h31}; step();
    idle(); fu_ready = 4'b1000; step();
    disp(0, 62, 1, 1, 2, 1); cdb_valid = 2'b01; cdb_tag = {6'h00, 6'h36}; fu_ready = '0; step();
    idle(); fu_ready = 4'b0001; step(); step();

    // Flush with concurrent dispatch and broadcast
    disp(1, 17, 3, 0, 4, 0); cdb_valid = 2'b11; cdb_tag = {6'h32, 6'h33}; flush = 1'b1; step();
    idle(); fu_ready = '1; step(); step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      en         = ($urandom % 8) != 0;
      flush      = ($urandom % 25) == 0;
      disp_valid = $urandom % 2;
      disp_fu    = FW'($urandom);
      disp_dest  = TW'($urandom);
      disp_t1    = TW'($urandom % 16);
      disp_t2    = TW'($urandom % 16);
      disp_t1r   = $urandom % 2;
      disp_t2r   = $urandom % 2;
      cdb_valid  = NC'($urandom);
      cdb_tag    = {TW'($urandom % 16), TW'($urandom % 16)};
      fu_ready   = NF'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
